memory_stage: RTL and testbench

- MEM stage of the 5-stage pipelined MIPS; sits directly downstream of Execute.
- Consumes the ALU result, instruction type and destination register from Execute.
- For LW, it performs a handshaked, multi-cycle data-memory read and stalls upstream while the read is outstanding.
- It produces the registered writeback value and target, plus the MEM/WB forwarding tap that Execute consumes.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/memory_stage.sv | 128 ++++++++++++
 tb/tb_memory_stage.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages: instruction type encodings,
// register index width and the memory-stage state encoding.
package mips_pkg;

  localparam int REG_W = 5;

  localparam logic [2:0] INST_NOP   = 3'd0;
  localparam logic [2:0] INST_ADDU  = 3'd1;
  localparam logic [2:0] INST_ADDIU = 3'd2;
  localparam logic [2:0] INST_MUL   = 3'd3;
  localparam logic [2:0] INST_LW    = 3'd4;
  localparam logic [2:0] INST_BEQ   = 3'd5;
  localparam logic [2:0] INST_JR    = 3'd6;
  localparam logic [2:0] INST_J     = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/memory_stage.sv
// MEM stage: passes ALU results to writeback and performs handshaked,
// multi-cycle LW reads, freezing upstream while a read is outstanding.
module memory_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_x70,
  input  logic              rst_x70,
  input  logic [31:0]       result_x70,
  input  logic [2:0]        inst_type_x70,
  input  logic [REG_W-1:0]  target_x70,
  output logic              dmem_req_x70,
  output logic [ADDR_W-1:0] dmem_addr_x70,
  input  logic [31:0]       dmem_rdata_x70,
  input  logic              dmem_ack_x70,
  output logic              hold_x70,
  output logic [31:0]       wb_value_x70,
  output logic [REG_W-1:0]  wb_target_x70,
  output logic              wb_we_x70,
  output logic [31:0]       mw_fwd_tapout_value_x70,
  output logic [REG_W-1:0]  mw_fwd_tapout_target_x70,
  output logic              mem_err_x70,
  output mem_state_e        mem_state_x70
);

  // Handshake: dmem_req_x70 is a level held from the LW capture edge until the
  // edge that sees dmem_ack_x70 (or the timeout abort); dmem_addr_x70 is stable
  // throughout, and dmem_rdata_x70 is taken only in the cycle ack is high.

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REG_W-1:0]  tgt_q, tgt_d;
  logic [31:0]       wv_q, wv_d;
  logic [REG_W-1:0]  wt_q, wt_d;
  logic              we_q, we_d;
  logic              err_q, err_d;

  always_ff @(posedge clk_x70 or posedge rst_x70) begin
    if (rst_x70) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      tgt_q   <= '0;
      wv_q    <= '0;
      wt_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
      wv_q    <= wv_d;
      wt_q    <= wt_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    tgt_d   = tgt_q;
    wv_d    = wv_q;
    wt_d    = wt_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        case (inst_type_x70)
          INST_ADDU, INST_ADDIU, INST_MUL: begin
            wv_d = result_x70;
            wt_d = target_x70;
            we_d = (target_x70 != '0);
          end
          INST_LW: begin
            if (result_x70[1:0] != 2'b00) begin
              err_d = 1'b1;
            end else begin
              addr_d  = result_x70[ADDR_W+1:2];
              tgt_d   = target_x70;
              cnt_d   = '0;
              state_d = WAIT;
            end
          end
          default: begin
            wv_d = '0;
            wt_d = '0;
          end
        endcase
      end
      WAIT: begin
        // Ack has priority over the timeout on the same edge.
        if (dmem_ack_x70) begin
          wv_d    = dmem_rdata_x70;
          wt_d    = tgt_q;
          we_d    = (tgt_q != '0);
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request and hold are both exactly the registered WAIT state.
  assign dmem_req_x70             = (state_q == WAIT);
  assign hold_x70                 = (state_q == WAIT);
  assign dmem_addr_x70            = addr_q;
  assign wb_value_x70             = wv_q;
  assign wb_target_x70            = wt_q;
  assign wb_we_x70                = we_q;
  assign mem_err_x70              = err_q;
  assign mw_fwd_tapout_value_x70  = wv_q;
  assign mw_fwd_tapout_target_x70 = we_q ? wt_q : '0;
  assign mem_state_x70            = state_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed stimulus pushes expected
// writeback/error events into a queue; a monitor pops them as the DUT emits them.
module tb_memory_stage;
  import mips_pkg::*;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 16;

  logic              clk_x70 = 1'b0;
  logic              rst_x70 = 1'b1;
  logic [31:0]       result_x70 = '0;
  logic [2:0]        inst_type_x70 = INST_NOP;
  logic [4:0]        target_x70 = '0;
  logic              dmem_req_x70;
  logic [ADDR_W-1:0] dmem_addr_x70;
  logic [31:0]       dmem_rdata_x70 = '0;
  logic              dmem_ack_x70 = 1'b0;
  logic              hold_x70;
  logic [31:0]       wb_value_x70;
  logic [4:0]        wb_target_x70;
  logic              wb_we_x70;
  logic [31:0]       tap_value;
  logic [4:0]        tap_target;
  logic              mem_err_x70;
  mem_state_e        mem_state_x70;

  memory_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_x70                  (clk_x70),
    .rst_x70                  (rst_x70),
    .result_x70               (result_x70),
    .inst_type_x70            (inst_type_x70),
    .target_x70               (target_x70),
    .dmem_req_x70             (dmem_req_x70),
    .dmem_addr_x70            (dmem_addr_x70),
    .dmem_rdata_x70           (dmem_rdata_x70),
    .dmem_ack_x70             (dmem_ack_x70),
    .hold_x70                 (hold_x70),
    .wb_value_x70             (wb_value_x70),
    .wb_target_x70            (wb_target_x70),
    .wb_we_x70                (wb_we_x70),
    .mw_fwd_tapout_value_x70  (tap_value),
    .mw_fwd_tapout_target_x70 (tap_target),
    .mem_err_x70              (mem_err_x70),
    .mem_state_x70            (mem_state_x70)
  );

  // clock / reset
  always #5 clk_x70 = ~clk_x70;

  int n_checks = 0;
  int n_pass   = 0;
  logic [37:0] exp_q[$];  // {is_err, target, value}
  bit done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk_x70);
    #2;
  endtask

  task automatic drive(input logic [2:0] t, input logic [31:0] r, input logic [4:0] tg);
    inst_type_x70 = t;
    result_x70    = r;
    target_x70    = tg;
  endtask

  task automatic push_wb(input logic [4:0] tg, input logic [31:0] v);
    exp_q.push_back({1'b0, tg, v});
  endtask

  task automatic push_err();
    exp_q.push_back({1'b1, 5'd0, 32'd0});
  endtask

  // scoreboard monitor
  always @(negedge clk_x70) begin
    if (!rst_x70 && !done && (wb_we_x70 || mem_err_x70)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {30'd0, mem_err_x70, wb_we_x70}, 32'd0);
      end else begin
        logic [37:0] e;
        e = exp_q.pop_front();
        chk("event_is_err", {31'd0, mem_err_x70}, {31'd0, e[37]});
        if (e[37]) begin
          chk("err_wb_we", {31'd0, wb_we_x70}, 32'd0);
        end else begin
          chk("wb_value", wb_value_x70, e[31:0]);
          chk("wb_target", {27'd0, wb_target_x70}, {27'd0, e[36:32]});
          chk("tap_value", tap_value, e[31:0]);
          chk("tap_target", {27'd0, tap_target}, {27'd0, e[36:32]});
        end
      end
    end
  end

  int cnt;

  initial begin
    // reset state
    #1;
    chk("rst_req", {31'd0, dmem_req_x70}, 32'd0);
    chk("rst_hold", {31'd0, hold_x70}, 32'd0);
    chk("rst_wb", {wb_value_x70[26:0], wb_target_x70}, 32'd0);
    chk("rst_we_err", {30'd0, wb_we_x70, mem_err_x70}, 32'd0);
    step();
    step();
    rst_x70 = 1'b0;

    // ADDU result 42 -> target 5
    drive(INST_ADDU, 32'd42, 5'd5);
    push_wb(5'd5, 32'd42);
    step();
    chk("addu_hold", {31'd0, hold_x70}, 32'd0);
    chk("addu_tap", {27'd0, tap_target}, 32'd5);

    // ADDIU to R0 never writes
    drive(INST_ADDIU, 32'd9, 5'd0);
    step();
    chk("r0_we", {31'd0, wb_we_x70}, 32'd0);
    chk("r0_tap", {27'd0, tap_target}, 32'd0);

    // aligned LW 0x10, ack on the third edge; ADDU driven during WAIT must be ignored
    drive(INST_LW, 32'h10, 5'd3);
    step();
    drive(INST_ADDU, 32'h55, 5'd9);
    chk("lw_req", {31'd0, dmem_req_x70}, 32'd1);
    chk("lw_addr", {22'd0, dmem_addr_x70}, 32'd4);
    chk("lw_hold", {31'd0, hold_x70}, 32'd1);
    step();
    chk("lw_req_c2", {31'd0, dmem_req_x70}, 32'd1);
    step();
    chk("lw_req_c3", {31'd0, dmem_req_x70}, 32'd1);
    dmem_ack_x70   = 1'b1;
    dmem_rdata_x70 = 32'hDEADBEEF;
    push_wb(5'd3, 32'hDEADBEEF);
    step();
    dmem_ack_x70 = 1'b0;
    drive(INST_NOP, 32'd0, 5'd0);
    chk("lw_done_req", {31'd0, dmem_req_x70}, 32'd0);
    chk("lw_done_hold", {31'd0, hold_x70}, 32'd0);
    step();

    // spurious ack in IDLE is ignored
    dmem_ack_x70 = 1'b1;
    dmem_rdata_x70 = 32'h1234;
    step();
    dmem_ack_x70 = 1'b0;
    chk("spur_we", {31'd0, wb_we_x70}, 32'd0);

    // misaligned LW 0x13
    drive(INST_LW, 32'h13, 5'd4);
    push_err();
    step();
    drive(INST_NOP, 32'd0, 5'd0);
    chk("mis_req", {31'd0, dmem_req_x70}, 32'd0);
    chk("mis_err", {31'd0, mem_err_x70}, 32'd1);
    step();
    chk("mis_err_pulse", {31'd0, mem_err_x70}, 32'd0);

    // LW with no ack: timeout after exactly TIMEOUT cycles
    drive(INST_LW, 32'h20, 5'd4);
    push_err();
    step();
    drive(INST_NOP, 32'd0, 5'd0);
    cnt = 0;
    while (dmem_req_x70 && cnt < 40) begin
      cnt++;
      step();
    end
    chk("to_req_cycles", cnt, TIMEOUT);
    chk("to_hold", {31'd0, hold_x70}, 32'd0);
    step();

    // ack on the timeout edge wins
    drive(INST_LW, 32'h24, 5'd6);
    step();
    drive(INST_NOP, 32'd0, 5'd0);
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    chk("late_req", {31'd0, dmem_req_x70}, 32'd1);
    dmem_ack_x70   = 1'b1;
    dmem_rdata_x70 = 32'hCAFE0016;
    push_wb(5'd6, 32'hCAFE0016);
    step();
    dmem_ack_x70 = 1'b0;
    chk("late_err", {31'd0, mem_err_x70}, 32'd0);
    chk("late_hold", {31'd0, hold_x70}, 32'd0);
    step();

    // reset asserted in the second WAIT cycle
    drive(INST_LW, 32'h30, 5'd2);
    step();
    drive(INST_NOP, 32'd0, 5'd0);
    step();
    #1;
    rst_x70 = 1'b1;
    #1;
    chk("rstw_req", {31'd0, dmem_req_x70}, 32'd0);
    chk("rstw_hold", {31'd0, hold_x70}, 32'd0);
    chk("rstw_we", {31'd0, wb_we_x70}, 32'd0);
    chk("rstw_tap", {27'd0, tap_target}, 32'd0);
    step();
    rst_x70 = 1'b0;
    dmem_ack_x70   = 1'b1;
    dmem_rdata_x70 = 32'hBAD0BAD0;
    step();
    dmem_ack_x70 = 1'b0;
    chk("rstw_late_we", {31'd0, wb_we_x70}, 32'd0);
    chk("rstw_state", {31'd0, mem_state_x70 == WAIT}, 32'd0);

    // MUL(t7) -> LW(t7) -> BEQ held upstream
    drive(INST_MUL, 32'd77, 5'd7);
    push_wb(5'd7, 32'd77);
    step();
    chk("b2b_mul_tap", {27'd0, tap_target}, 32'd7);
    drive(INST_LW, 32'h40, 5'd7);
    step();
    drive(INST_BEQ, 32'h1, 5'd0);
    chk("b2b_wait_tap0", {27'd0, tap_target}, 32'd0);
    chk("b2b_addr", {22'd0, dmem_addr_x70}, 32'h10);
    step();
    chk("b2b_wait_tap1", {27'd0, tap_target}, 32'd0);
    dmem_ack_x70   = 1'b1;
    dmem_rdata_x70 = 32'h0BADF00D;
    push_wb(5'd7, 32'h0BADF00D);
    step();
    dmem_ack_x70 = 1'b0;
    chk("b2b_lw_tap", {27'd0, tap_target}, 32'd7);
    chk("b2b_hold", {31'd0, hold_x70}, 32'd0);
    step();
    drive(INST_NOP, 32'd0, 5'd0);
    chk("b2b_beq_we", {31'd0, wb_we_x70}, 32'd0);
    chk("b2b_beq_tap", {27'd0, tap_target}, 32'd0);
    step();
    step();

    done = 1'b1;
    chk("queue_drained", exp_q.size(), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
